// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths,
// FSM state encodings, operation select and the ALU opcodes that start it.
package multdiv_pkg;

    localparam int DATA_W   = 32;  // operand/result width, also the iteration count
    localparam int CNT_BITS = 6;   // iteration counter width, must hold DATA_W

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // R-type ALU opcodes decoded into ctrl_MULT / ctrl_DIV upstream
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

endpackage

// File: rtl/multdiv_if.sv
// Start/operand/result bundle between the execute stage and multdiv.
interface multdiv_if
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for multdiv: IDLE/BUSY/DONE FSM plus the iteration counter.
// A start in any state (re)loads the datapath, so a start while BUSY aborts.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = CNT_BITS
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic last
);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // State and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state, counter and datapath strobes
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = start;
        step    = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = BUSY;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (start) begin
                    cnt_n = '0;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        last    = 1'b1;
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = start ? BUSY : IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring on
// magnitudes) unit. One iteration per cycle; the result register is written
// on the edge that completes the last iteration and holds until the next one.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = CNT_BITS
) (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);
    logic start, load, step, last, done;
    op_t  op;

    // Booth: {hi, lo, qm1}; hi carries one guard bit so adding/subtracting
    // the most negative multiplicand cannot wrap before the arithmetic shift.
    logic [WIDTH:0]   hi, hi_n, booth_sum;
    logic [WIDTH-1:0] lo, lo_n, mcand;
    logic             qm1;

    // Divide: signed partial remainder (two guard bits), dividend bits shift
    // out of quo's MSB while quotient bits shift into its LSB.
    logic [WIDTH+1:0] rem, rem_n, rem_sh;
    logic [WIDTH-1:0] quo, quo_n, dvs;
    logic             qsign, dzero, dovf;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   div_q, a_mag, b_mag;
    logic [WIDTH-1:0]   res_n;
    logic               exc_n;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;

    multdiv_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
        .clock (clock),
        .reset (reset),
        .start (start),
        .busy  (bus.busy),
        .done  (done),
        .load  (load),
        .step  (step),
        .last  (last)
    );

    assign bus.data_resultRDY = done;

    assign a_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // One Booth step and one non-restoring step, plus final result forming
    always_comb begin
        case ({lo[0], qm1})
            2'b01:   booth_sum = hi + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = hi - {mcand[WIDTH-1], mcand};
            default: booth_sum = hi;
        endcase
        hi_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        lo_n = {booth_sum[0], lo[WIDTH-1:1]};

        rem_sh = {rem[WIDTH:0], quo[WIDTH-1]};
        rem_n  = rem[WIDTH+1] ? rem_sh + {2'b00, dvs} : rem_sh - {2'b00, dvs};
        quo_n  = {quo[WIDTH-2:0], ~rem_n[WIDTH+1]};

        prod  = {hi_n[WIDTH-1:0], lo_n};
        div_q = qsign ? -quo_n : quo_n;

        if (op == OP_MULT) begin
            res_n = prod[WIDTH-1:0];
            exc_n = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
        end else begin
            res_n = dzero ? '0 : div_q;
            exc_n = dzero | dovf;
        end
    end

    // Operand capture on start, one iteration per BUSY cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op    <= OP_MULT;
            hi    <= '0;
            lo    <= '0;
            qm1   <= 1'b0;
            mcand <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            qsign <= 1'b0;
            dzero <= 1'b0;
            dovf  <= 1'b0;
        end else if (load) begin
            op    <= bus.ctrl_MULT ? OP_MULT : OP_DIV;
            hi    <= '0;
            lo    <= bus.data_operandB;
            qm1   <= 1'b0;
            mcand <= bus.data_operandA;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            qsign <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            dzero <= (bus.data_operandB == '0);
            dovf  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (bus.data_operandB == {WIDTH{1'b1}});
        end else if (step) begin
            if (op == OP_MULT) begin
                hi  <= hi_n;
                lo  <= lo_n;
                qm1 <= lo[0];
            end else begin
                rem <= rem_n;
                quo <= quo_n;
            end
        end
    end

    // Result registers, written only when the last iteration completes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
        end else if (last) begin
            bus.data_result    <= res_n;
            bus.data_exception <= exc_n;
        end
    end

endmodule

// File: tb/tb_multdiv.sv
// Directed-vector bench for multdiv: latency, results, exceptions, start
// priority, abort/restart, operand capture, output hold and async reset.
module tb_multdiv;
    logic clock;
    logic reset;

    int vecs    = 0;
    int miscmp  = 0;

    multdiv_if bus ();

    multdiv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a start for one edge, then scramble operands so capture is tested
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Count edges after the start edge until RDY, then check result and RDY width
    task automatic wait_rdy(input string tag, input int lat, input logic [31:0] res, input logic exc);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!bus.data_resultRDY && n < 40);
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " result"}, bus.data_result, res);
        chk({tag, " exc"}, 32'(bus.data_exception), 32'(exc));
        chk({tag, " busy in done"}, 32'(bus.busy), 32'd0);
        @(posedge clock);
        #1;
        chk({tag, " rdy one cycle"}, 32'(bus.data_resultRDY), 32'd0);
    endtask

    task automatic run(input string tag, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic exc);
        start_op(m, d, a, b);
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        wait_rdy(tag, 32, res, exc);
    endtask

    initial begin
        int seen;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        reset             = 1'b1;
        #1;
        chk("reset result", bus.data_result, 32'd0);
        chk("reset exc", 32'(bus.data_exception), 32'd0);
        chk("reset rdy", 32'(bus.data_resultRDY), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run("mul 7*-3",        1, 0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run("mul 2^16*2^16",   1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1);
        run("mul max*1",       1, 0, 32'h7FFF_FFFF, 32'd1,        32'h7FFF_FFFF, 0);
        run("mul min*min",     1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1);
        run("mul min*-1",      1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("mul -5*-6",       1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,       0);
        run("div -7/2",        0, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0);
        run("div 5/0",         0, 1, 32'd5,        32'd0,        32'd0,        1);
        run("div min/-1",      0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("div -100/-7",     0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,       0);
        run("div 7/-8",        0, 1, 32'd7,        32'hFFFF_FFF8, 32'd0,        0);
        run("both high 6,3",   1, 1, 32'd6,        32'd3,        32'd18,       0);

        // Output hold: result stays after RDY while inputs wander
        repeat (5) @(posedge clock);
        #1;
        chk("hold result", bus.data_result, 32'd18);

        // Abort: MULT 3*4 at edge 0, DIV 20/5 at edge 10 -> RDY at edge 42
        start_op(1, 0, 32'd3, 32'd4);
        seen = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) seen++;
        end
        chk("abort no early rdy", 32'(seen), 32'd0);
        start_op(0, 1, 32'd20, 32'd5);
        wait_rdy("restart div", 32, 32'd4, 0);

        // Async reset in the middle of a divide
        start_op(0, 1, 32'd100, 32'd3);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midop reset result", bus.data_result, 32'd0);
        chk("midop reset busy", 32'(bus.busy), 32'd0);
        chk("midop reset rdy", 32'(bus.data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) seen++;
        end
        chk("post reset no rdy", 32'(seen), 32'd0);
        run("mul 2*2 after reset", 1, 0, 32'd2, 32'd2, 32'd4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
